// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet RX frame packer.
// Purpose: FIFO word field positions, packer state encoding and the
//          free-space helper used by frame admission.
// Ports:   none (package).
package eth_rx_pkg;

  // FIFO word layout: [31:0] data, [33:32] valid bytes minus 1, [34] eop, [35] err
  localparam int BCNT_LSB = 32;
  localparam int BCNT_MSB = 33;
  localparam int EOP_BIT  = 34;
  localparam int ERR_BIT  = 35;
  localparam int WORD_W   = 36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DROP = 2'd2
  } rx_state_t;

  // Free FIFO words = capacity minus current fill. The caller trims the
  // result to DEPTH_WIDTH+2 bits so a full FIFO reads as exactly zero.
  function automatic logic [31:0] calc_free_words(input int unsigned depth_width,
                                                  input logic [31:0] water_level);
    return (32'd1 << depth_width) - water_level;
  endfunction

endpackage

// File: rtl/eth_rx_sat_cnt16.sv
// 16-bit event counter used for the packer statistics.
// Purpose: counts single-cycle increment pulses; SATURATE=1 sticks at
//          0xFFFF, SATURATE=0 wraps to zero.
// Ports:   clk, rst_n (sync, active-low), inc (increment pulse),
//          count (current value).
module eth_rx_sat_cnt16 #(
  parameter bit SATURATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  // Increment unless saturating and already at the top value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !(SATURATE && (count == 16'hFFFF))) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/eth_rx_frame_packer.sv
// Ethernet RX frame packer: write-side feeder of the RX buffer FIFO.
// Purpose: packs the MAC byte stream little-endian into 36-bit FIFO words,
//          admits a frame only when the FIFO can hold a maximum-length
//          frame, truncates oversize frames and keeps statistics.
// Ports:   wr_clk / wr_rst_n   clock and sync active-low reset
//          rx_data/rx_valid/rx_last/rx_err   MAC receive byte stream
//          wr_data/wr_en       FIFO write word and strobe
//          wr_full/wr_water_level   FIFO write-side status
//          frame_cnt/drop_cnt/trunc_cnt   statistics
//          ovf_err             sticky write-while-full flag
module eth_rx_frame_packer
  import eth_rx_pkg::*;
#(
  parameter int DEPTH_WIDTH     = 10,
  parameter int MAX_FRAME_BYTES = 1536,
  parameter int ADMIT_MARGIN    = 2
) (
  input  logic                   wr_clk,
  input  logic                   wr_rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  input  logic                   rx_err,
  output logic [35:0]            wr_data,
  output logic                   wr_en,
  input  logic                   wr_full,
  input  logic [DEPTH_WIDTH:0]   wr_water_level,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            drop_cnt,
  output logic [15:0]            trunc_cnt,
  output logic                   ovf_err
);

  localparam int MAX_WORDS = MAX_FRAME_BYTES / 4;
  localparam int FREE_W    = DEPTH_WIDTH + 2;
  localparam int BCNT_W    = $clog2(MAX_FRAME_BYTES + 1);

  rx_state_t         state;
  logic [1:0]        lane;
  logic [BCNT_W-1:0] byte_cnt;
  logic              err_acc;
  logic [31:0]       word_buf;

  logic [FREE_W-1:0] free_words;
  logic              admit;
  logic              at_max;
  logic [31:0]       next_word;
  logic [WORD_W-1:0] emit_word;
  logic              emit;
  logic              emit_eop;
  logic              emit_err;
  logic              frame_hit;
  logic              drop_hit;
  logic              trunc_hit;

  assign free_words = FREE_W'(calc_free_words(DEPTH_WIDTH, 32'(wr_water_level)));
  assign admit      = (free_words >= FREE_W'(MAX_WORDS + ADMIT_MARGIN));
  // The incoming byte is the one that brings the frame to its length limit.
  assign at_max     = (byte_cnt == BCNT_W'(MAX_FRAME_BYTES - 1));

  // Per-byte decisions: merge the byte into the word under construction and
  // decide whether this byte completes a word, a frame or a truncation.
  // Lane 0 starts from zero so unused upper lanes of a short word read 0.
  always_comb begin
    next_word = (lane == 2'd0) ? 32'd0 : word_buf;
    next_word[{lane, 3'b000} +: 8] = rx_data;
    emit      = 1'b0;
    emit_eop  = 1'b0;
    emit_err  = 1'b0;
    drop_hit  = 1'b0;
    trunc_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (!admit) begin
            drop_hit = 1'b1;
          end else if (rx_last) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = rx_err;
          end
        end
      end
      ST_PACK: begin
        if (rx_valid) begin
          if (rx_last) begin
            emit     = 1'b1;
            emit_eop = 1'b1;
            emit_err = err_acc | rx_err;
          end else if (at_max) begin
            emit      = 1'b1;
            emit_eop  = 1'b1;
            emit_err  = 1'b1;
            trunc_hit = 1'b1;
          end else if (lane == 2'd3) begin
            emit = 1'b1;
          end
        end
      end
      default: ;
    endcase
    frame_hit = emit && emit_eop && !emit_err;
    emit_word = '0;
    emit_word[31:0]              = next_word;
    emit_word[BCNT_MSB:BCNT_LSB] = lane;
    emit_word[EOP_BIT]           = emit_eop;
    emit_word[ERR_BIT]           = emit_err;
  end

  // Packer FSM with registered FIFO write port. A frame-ending word clears
  // lane, byte count and error accumulator so the next frame starts clean.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state    <= ST_IDLE;
      lane     <= 2'd0;
      byte_cnt <= '0;
      err_acc  <= 1'b0;
      word_buf <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      ovf_err  <= 1'b0;
    end else begin
      wr_en <= emit;
      if (emit) begin
        wr_data <= emit_word;
      end
      if (wr_en && wr_full) begin
        ovf_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (!admit) begin
              state <= rx_last ? ST_IDLE : ST_DROP;
            end else if (!rx_last) begin
              state    <= ST_PACK;
              lane     <= 2'd1;
              byte_cnt <= BCNT_W'(1);
              err_acc  <= rx_err;
              word_buf <= next_word;
            end
          end
        end
        ST_PACK: begin
          if (rx_valid) begin
            if (emit_eop) begin
              state    <= rx_last ? ST_IDLE : ST_DROP;
              lane     <= 2'd0;
              byte_cnt <= '0;
              err_acc  <= 1'b0;
            end else begin
              lane     <= lane + 2'd1;
              byte_cnt <= byte_cnt + BCNT_W'(1);
              err_acc  <= err_acc | rx_err;
              word_buf <= next_word;
            end
          end
        end
        ST_DROP: begin
          if (rx_valid && rx_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  eth_rx_sat_cnt16 #(.SATURATE(1'b0)) u_frame_cnt (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .inc   (frame_hit),
    .count (frame_cnt)
  );

  eth_rx_sat_cnt16 #(.SATURATE(1'b1)) u_drop_cnt (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .inc   (drop_hit),
    .count (drop_cnt)
  );

  eth_rx_sat_cnt16 #(.SATURATE(1'b1)) u_trunc_cnt (
    .clk   (wr_clk),
    .rst_n (wr_rst_n),
    .inc   (trunc_hit),
    .count (trunc_cnt)
  );

endmodule

// File: tb/tb_eth_rx_frame_packer.sv
// Self-checking bench for eth_rx_frame_packer: directed and randomized
// frames compared against a frame-level reference model.
module tb_eth_rx_frame_packer;

  localparam int MAX_BYTES  = 1536;
  localparam int FIFO_WORDS = 1024;
  localparam int ADMIT_NEED = MAX_BYTES / 4 + 2;

  logic        wr_clk = 1'b0;
  logic        wr_rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_last;
  logic        rx_err;
  logic [35:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic [10:0] wr_water_level;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] trunc_cnt;
  logic        ovf_err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_bytes[$];
  logic        tx_err[$];
  logic [35:0] exp_q[$];
  logic [35:0] obs_q[$];
  logic [15:0] exp_frame;
  logic [15:0] exp_drop;
  logic [15:0] exp_trunc;
  logic        exp_ovf;

  eth_rx_frame_packer dut (
    .wr_clk         (wr_clk),
    .wr_rst_n       (wr_rst_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_last        (rx_last),
    .rx_err         (rx_err),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt),
    .trunc_cnt      (trunc_cnt),
    .ovf_err        (ovf_err)
  );

  always #5 wr_clk = ~wr_clk;

  // Capture every FIFO write away from the active edge.
  always @(negedge wr_clk) begin
    if (wr_en === 1'b1) obs_q.push_back(wr_data);
  end

  task automatic checkOutput(input string tag, input logic [35:0] observed,
                             input logic [35:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      rx_last  = 1'($urandom);
      rx_err   = 1'($urandom);
      @(posedge wr_clk); #1;
    end
    rx_last = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic buildFrame(input int len, input bit incr, input int err_idx,
                            input bit rand_err);
    tx_bytes.delete();
    tx_err.delete();
    for (int i = 0; i < len; i++) begin
      tx_bytes.push_back(incr ? 8'(i) : 8'($urandom));
      tx_err.push_back(rand_err ? ($urandom_range(0, 15) == 0) : (i == err_idx));
    end
  endtask

  // Drives the queued bytes; rx_last marks the final byte only if end_frame.
  task automatic applyStimulus(input bit end_frame, input bit gaps);
    for (int i = 0; i < tx_bytes.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = tx_bytes[i];
      rx_err   = tx_err[i];
      rx_last  = end_frame && (i == tx_bytes.size() - 1);
      @(posedge wr_clk); #1;
      if (gaps && ($urandom_range(0, 3) == 0)) idleCycles($urandom_range(1, 3));
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_err   = 1'b0;
  endtask

  // Frame-level reference: admission from free space, then words of up to
  // four bytes from the (possibly truncated) byte list.
  task automatic modelFrame(input int level);
    int  len, n, nb;
    bit  trunc, anyerr;
    logic [35:0] w;
    if (FIFO_WORDS - level < ADMIT_NEED) begin
      if (exp_drop != 16'hFFFF) exp_drop++;
      return;
    end
    len    = tx_bytes.size();
    trunc  = (len > MAX_BYTES);
    n      = trunc ? MAX_BYTES : len;
    anyerr = 1'b0;
    for (int i = 0; i < n; i++) anyerr |= tx_err[i];
    for (int s = 0; s < n; s += 4) begin
      nb = (n - s >= 4) ? 4 : n - s;
      w  = '0;
      for (int b = 0; b < nb; b++) w[8*b +: 8] = tx_bytes[s+b];
      w[33:32] = 2'(nb - 1);
      w[34]    = (s + nb == n);
      w[35]    = (s + nb == n) && (trunc || anyerr);
      exp_q.push_back(w);
    end
    if (trunc && exp_trunc != 16'hFFFF) exp_trunc++;
    if (!trunc && !anyerr) exp_frame++;
  endtask

  task automatic compareFrame(input string tag);
    int m;
    checkOutput({tag, "_nwords"}, 36'(obs_q.size()), 36'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      checkOutput($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
    checkOutput({tag, "_frame_cnt"}, 36'(frame_cnt), 36'(exp_frame));
    checkOutput({tag, "_drop_cnt"}, 36'(drop_cnt), 36'(exp_drop));
    checkOutput({tag, "_trunc_cnt"}, 36'(trunc_cnt), 36'(exp_trunc));
    checkOutput({tag, "_ovf_err"}, 36'(ovf_err), 36'(exp_ovf));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic runFrame(input string tag, input int level, input bit gaps);
    wr_water_level = 11'(level);
    modelFrame(level);
    applyStimulus(1'b1, gaps);
    idleCycles(3);
    compareFrame(tag);
  endtask

  initial begin
    int lvl;
    wr_rst_n = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; rx_last = 1'b0;
    rx_err = 1'b0; wr_full = 1'b0; wr_water_level = 11'd0;
    exp_frame = '0; exp_drop = '0; exp_trunc = '0; exp_ovf = 1'b0;
    repeat (3) @(posedge wr_clk);
    #1;
    wr_rst_n = 1'b1;
    idleCycles(2);
    checkOutput("rst_wr_en", 36'(wr_en), 36'd0);
    checkOutput("rst_wr_data", wr_data, 36'd0);
    checkOutput("rst_frame_cnt", 36'(frame_cnt), 36'd0);
    checkOutput("rst_drop_cnt", 36'(drop_cnt), 36'd0);
    checkOutput("rst_trunc_cnt", 36'(trunc_cnt), 36'd0);
    checkOutput("rst_ovf_err", 36'(ovf_err), 36'd0);

    buildFrame(64, 1'b1, -1, 1'b0);
    wr_water_level = 11'd0;
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    checkOutput("f64_word0", obs_q[0], 36'h303020100);
    checkOutput("f64_word15", obs_q[15], 36'h73F3E3D3C);
    compareFrame("f64");

    buildFrame(65, 1'b1, -1, 1'b0);
    wr_water_level = 11'd0;
    modelFrame(0);
    applyStimulus(1'b1, 1'b1);
    idleCycles(3);
    checkOutput("f65_last", obs_q[16], 36'h400000040);
    compareFrame("f65");

    buildFrame(100, 1'b0, 50, 1'b0);
    runFrame("f100_err", 0, 1'b1);

    buildFrame(40, 1'b0, -1, 1'b0);
    runFrame("drop700", 700, 1'b0);
    buildFrame(20, 1'b0, -1, 1'b0);
    runFrame("after_drop", 0, 1'b0);

    buildFrame(10, 1'b0, -1, 1'b0);
    runFrame("thresh_admit", FIFO_WORDS - ADMIT_NEED, 1'b0);
    buildFrame(10, 1'b0, -1, 1'b0);
    runFrame("thresh_drop", FIFO_WORDS - ADMIT_NEED + 1, 1'b0);

    buildFrame(MAX_BYTES, 1'b0, -1, 1'b0);
    runFrame("exact_max", 0, 1'b0);

    buildFrame(1600, 1'b1, -1, 1'b0);
    wr_water_level = 11'd0;
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    checkOutput("trunc_w383", obs_q[383], 36'hFFFFEFDFC);
    compareFrame("trunc1600");
    buildFrame(1, 1'b0, -1, 1'b0);
    tx_bytes[0] = 8'hA5;
    wr_water_level = 11'd0;
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    checkOutput("one_byte_word", obs_q[0], 36'h4000000A5);
    compareFrame("one_byte");

    // Back-to-back frames with no idle between rx_last and the next byte.
    wr_water_level = 11'd0;
    buildFrame(9, 1'b0, -1, 1'b1);
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    buildFrame(1, 1'b0, -1, 1'b1);
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    buildFrame(6, 1'b0, -1, 1'b1);
    modelFrame(0);
    applyStimulus(1'b1, 1'b0);
    idleCycles(3);
    compareFrame("b2b");

    for (int k = 0; k < 12; k++) begin
      lvl = ($urandom_range(0, 2) == 0) ? $urandom_range(FIFO_WORDS - ADMIT_NEED + 1, FIFO_WORDS)
                                        : $urandom_range(0, FIFO_WORDS - ADMIT_NEED);
      buildFrame($urandom_range(1, 80), 1'b0, -1, 1'b1);
      runFrame($sformatf("rand%0d", k), lvl, 1'b1);
    end

    wr_full = 1'b1;
    exp_ovf = 1'b1;
    buildFrame(5, 1'b0, -1, 1'b0);
    runFrame("ovf", 0, 1'b0);
    wr_full = 1'b0;
    buildFrame(3, 1'b0, -1, 1'b0);
    runFrame("ovf_sticky", 0, 1'b0);

    // Reset after the second byte of a frame discards the partial word.
    wr_water_level = 11'd0;
    buildFrame(2, 1'b0, -1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    wr_rst_n = 1'b0;
    idleCycles(2);
    wr_rst_n = 1'b1;
    exp_frame = '0; exp_drop = '0; exp_trunc = '0; exp_ovf = 1'b0;
    idleCycles(3);
    compareFrame("rst_mid");
    buildFrame(7, 1'b0, -1, 1'b0);
    runFrame("after_rst", 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
